gs232c_ras_trk: RTL

- Event tracker that drives the br-stage and wb-stage update ports of the 16-entry return address stack.
- Records every predicted call/return at fetch, in program order, in a small circular queue.
- Replays each record exactly once when the instruction resolves in the branch stage, and once more when it retires at writeback.
- Also generates the RAS RAM-init sequence after reset.

---
 rtl/gs232c_ras_pkg.sv | 13 +
 rtl/gs232c_ras_init_cnt.sv | 20 ++
 rtl/gs232c_ras_trk.sv | 100 ++++++++++
 3 files changed

// File: rtl/gs232c_ras_pkg.sv
// gs232c_ras_pkg: shared record type, default sizes and pointer-width helper for the RAS tracker.
package gs232c_ras_pkg;
  localparam int PCW_DEF = 30;
  localparam int RAS_DEPTH_DEF = 16;
  typedef struct packed {
    logic link;
    logic jrra;
    logic [PCW_DEF-1:0] link_pc;
  } ras_rec_t;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/gs232c_ras_init_cnt.sv
// gs232c_ras_init_cnt: raminit_valid high for N consecutive cycles after reset releases.
module gs232c_ras_init_cnt #(
  parameter int N = 16
) (
  input  logic clock,
  input  logic reset,
  output logic raminit_valid
);
  localparam int CW = $clog2(N + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      raminit_valid <= 1'b0;
    end else begin
      cnt <= (cnt == CW'(N)) ? cnt : cnt + CW'(1);
      raminit_valid <= cnt != CW'(N);
    end
  end
endmodule

// File: rtl/gs232c_ras_trk.sv
// gs232c_ras_trk: in-order call/return record queue replayed to RAS br and wb ports.
// Optional GS232C_RAS_TRK_CHECK_EN adds a sticky err output for ignored steps/pushes.
module gs232c_ras_trk
  import gs232c_ras_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PCW = PCW_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pr_valid,
  input  logic                   pr_link,
  input  logic                   pr_jrra,
  input  logic [PCW-1:0]         pr_link_pc,
  output logic                   pr_ready,
  input  logic                   br_step,
  input  logic                   br_cancel,
  input  logic                   wb_step,
  input  logic                   wb_cancel,
  output logic                   br_link,
  output logic                   br_jrra,
  output logic [PCW-1:0]         br_link_pc,
  output logic                   wb_link,
  output logic                   wb_jrra,
  output logic [PCW-1:0]         wb_link_pc,
  output logic                   raminit_valid,
  output logic [$clog2(DEPTH):0] count
`ifdef GS232C_RAS_TRK_CHECK_EN
  ,
  output logic                   err
`endif
);
  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  logic [PW-1:0] tail, bp, hp, bp_n, hp_n;
  logic [PCW-1:0] pc_mem [DEPTH];
  logic [DEPTH-1:0] link_mem, jrra_mem;
  logic full, push, br_do, wb_do;
  gs232c_ras_init_cnt #(.N(RAS_DEPTH)) u_init (
    .clock(clock),
    .reset(reset),
    .raminit_valid(raminit_valid)
  );
  assign count = tail - hp;
  assign full = count == PW'(DEPTH);
  assign pr_ready = !full && !raminit_valid;
  assign push = pr_valid && pr_ready && (pr_link || pr_jrra) && !br_cancel && !wb_cancel;
  assign br_do = br_step && !raminit_valid && bp != tail && !wb_cancel;
  assign wb_do = wb_step && !raminit_valid && hp != bp;
  assign bp_n = bp + PW'(br_do);
  assign hp_n = hp + PW'(wb_do);
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[tail[AW-1:0]] <= pr_link_pc;
      link_mem[tail[AW-1:0]] <= pr_link;
      jrra_mem[tail[AW-1:0]] <= pr_jrra;
    end
  end
  // wb_cancel collapses everything onto the retire pointer; br_cancel onto resolve.
  always_ff @(posedge clock) begin
    if (reset) begin
      tail <= '0;
      bp <= '0;
      hp <= '0;
      br_link <= 1'b0;
      br_jrra <= 1'b0;
      br_link_pc <= '0;
      wb_link <= 1'b0;
      wb_jrra <= 1'b0;
      wb_link_pc <= '0;
    end else begin
      hp <= hp_n;
      bp <= wb_cancel ? hp_n : bp_n;
      tail <= wb_cancel ? hp_n : br_cancel ? bp_n : tail + PW'(push);
      br_link <= br_do && link_mem[bp[AW-1:0]];
      br_jrra <= br_do && jrra_mem[bp[AW-1:0]];
      br_link_pc <= br_do ? pc_mem[bp[AW-1:0]] : '0;
      wb_link <= wb_do && link_mem[hp[AW-1:0]];
      wb_jrra <= wb_do && jrra_mem[hp[AW-1:0]];
      wb_link_pc <= wb_do ? pc_mem[hp[AW-1:0]] : '0;
    end
  end
`ifdef GS232C_RAS_TRK_CHECK_EN
  logic ign_br, ign_wb, ign_pr;
  assign ign_br = br_step && !raminit_valid && bp == tail;
  assign ign_wb = wb_step && !raminit_valid && hp == bp;
  assign ign_pr = pr_valid && (pr_link || pr_jrra) && !pr_ready && !raminit_valid;
  always_ff @(posedge clock) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= err || ign_br || ign_wb || ign_pr;
      if (ign_br) $error("gs232c_ras_trk: br_step with nothing to resolve");
      if (ign_wb) $error("gs232c_ras_trk: wb_step with nothing to retire");
      if (ign_pr) $error("gs232c_ras_trk: call/return presented while queue not ready");
    end
  end
`endif
endmodule
